bin_xfer_ctrl: RTL and testbench
================================

# bin_xfer_ctrl

Sequences transfer of one bin's contents between the bin memories (clauses, variable states, level states) and the sat engine's local arrays. It sits beside `bin_manager`. The block accepts a load or store command for a bin id and drives the engine's one-hot write/read strobes and the memory address and write ports. It signals completion with a one-cycle done pulse.

## Interface
Parameters:
- NUM_CLAUSES_A_BIN, 8, clauses per bin (NC)
- NUM_VARS_A_BIN, 8, variables per bin (NV)
- NUM_LVLS_A_BIN, 8, levels per bin (NL)
- WIDTH_BIN_ID, 10, bin id width
- WIDTH_VAR_STATES, 11, bits per variable state
- WIDTH_LVL_STATES, 19, bits per level state
- ADDR_WIDTH_CLAUSES / ADDR_WIDTH_VAR_STATES / ADDR_WIDTH_LVL_STATES, 9 each, memory address widths

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- load_i  in  1  start memory→engine transfer
- store_i  in  1  start engine→memory transfer
- bin_id_i  in  WIDTH_BIN_ID  bin to transfer; sampled on accept
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- wr_carray_o / rd_carray_o  out  NC  one-hot engine clause write/read strobe
- clause_o  out  NV*2  clause to engine;  clause_i  in  NV*2  clause from engine
- wr_var_states_o  out  NV;  var_states_o  out  WIDTH_VAR_STATES*NV;  var_states_i  in  same width
- wr_lvl_states_o  out  NL;  lvl_states_o  out  WIDTH_LVL_STATES*NL;  lvl_states_i  in  same width
- cmem_addr_o  out  ADDR_WIDTH_CLAUSES;  cmem_we_o  out 1;  cmem_wdata_o  out NV*2;  cmem_rdata_i  in NV*2
- vmem_addr_o / vmem_we_o / vmem_wdata_o / vmem_rdata_i: the same set for variable states (word = WIDTH_VAR_STATES)
- lmem_addr_o / lmem_we_o / lmem_wdata_o / lmem_rdata_i: the same set for level states (word = WIDTH_LVL_STATES)

## Operation
- States: IDLE, L_CLS, L_VAR, L_LVL, S_CLS, S_VAR, S_LVL, DONE.
- IDLE: a request is accepted when load_i or store_i is high. bin_id_i is latched on accept.
  - Both high at once: store wins and load is dropped, so the engine is saved before it is overwritten.
- Requests arriving while not in IDLE are ignored; there is no queue.
- Memory address for item k = (bin_id × N + k) mod 2^ADDR_WIDTH, where N is NC, NV or NL for that phase.
- Load sequence: L_CLS → L_VAR → L_LVL → DONE.
  - Each phase has a counter k = 0..N, lasting N+1 cycles.
  - For k<N: the memory address for item k is issued with we=0.
  - For k≥1: engine write strobe bit k-1 is asserted, carrying the previous cycle's rdata.
  - That data is placed in slot k-1 of the wide vector; other slots are 0.
- Store sequence: S_CLS → S_VAR → S_LVL → DONE.
  - Each phase lasts N cycles.
  - At k: read strobe bit k is asserted; var/lvl phases use `wr_*` low and the engine's wide vector is read directly.
  - The engine's item k (combinational) is written to memory at item k's address with we=1 in the same cycle.
- DONE lasts one cycle: done_o=1, then return to IDLE.
- Strobes are one-hot or zero; they are never multi-hot. All memory we are 0 outside store phases.

## Timing
- Reset values: every output is 0, state is IDLE, counters are 0. Reset mid-transfer aborts without a done pulse.
- Accept at cycle 0 → busy_o high from cycle 1 through the DONE cycle inclusive.
- Load: done_o at cycle NC+NV+NL+4 (28 at defaults).
- Store: done_o at cycle NC+NV+NL+1 (25 at defaults).
- A new request is accepted on the cycle after DONE at the earliest.
- Memory read latency is exactly 1 cycle. The engine read path is combinational.

## Configuration
- BIN_XFER_PERF_EN defined:
  - Adds output xfer_cnt_o [15:0], counting completed transfers on each done_o.
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `sat_bin_pkg`:
  - state enum
  - phase-counter width constant (clog2 of max(NC,NV,NL)+1)
  - memory-word width constants
- One sub-module, `xfer_phase_cnt`: counter with terminal-count flag and one-hot decode, instanced per active phase or shared.

## Test plan
- Load bin 3, memories preloaded with clause = index:
  - cmem_addr_o 24..31 on cycles 1..8.
  - wr_carray_o 8'h01..8'h80 on cycles 2..9.
  - done_o at cycle 28.
- Store bin 0, engine clauses distinct:
  - cmem_we_o=1 on cycles 1..8 at addr 0..7 with matching data.
  - done_o at cycle 25; memory is then read back equal.
- load_i and store_i high together → store sequence runs; load is never executed.
- load_i pulsed at cycle 10 during a load → ignored; exactly one done_o.
- rst low at cycle 12 of a load → all outputs 0 immediately; no done_o; next load completes normally.
- BIN_XFER_PERF_EN: three transfers → xfer_cnt_o=3. Preload counter 16'hFFFF, one more transfer → stays 16'hFFFF.

Source files
------------

// File: rtl/sat_bin_pkg.sv
// Shared definitions for the bin transfer sequencer: state encoding,
// phase-counter sizing, memory word widths and the bin item address helper.
package sat_bin_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    L_CLS = 3'd1,
    L_VAR = 3'd2,
    L_LVL = 3'd3,
    S_CLS = 3'd4,
    S_VAR = 3'd5,
    S_LVL = 3'd6,
    DONE  = 3'd7
  } xfer_state_e;

  localparam int unsigned DEF_NUM_CLAUSES_A_BIN = 8;
  localparam int unsigned DEF_NUM_VARS_A_BIN    = 8;
  localparam int unsigned DEF_NUM_LVLS_A_BIN    = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A load phase counts 0..N inclusive, so the counter must hold max(N).
  function automatic int unsigned phase_cnt_w(input int unsigned nc, input int unsigned nv,
                                              input int unsigned nl);
    return $clog2(max3(nc, nv, nl) + 1);
  endfunction

  // A clause carries two literal bits per variable of the bin.
  function automatic int unsigned clause_w(input int unsigned nv);
    return 2 * nv;
  endfunction

  localparam int unsigned PHASE_CNT_W  = phase_cnt_w(DEF_NUM_CLAUSES_A_BIN,
                                                     DEF_NUM_VARS_A_BIN,
                                                     DEF_NUM_LVLS_A_BIN);
  localparam int unsigned CLAUSE_W     = clause_w(DEF_NUM_VARS_A_BIN);
  localparam int unsigned VAR_STATE_W  = 11;
  localparam int unsigned LVL_STATE_W  = 19;

  // Item k of a bin lives at bin*N + k; callers truncate to their address width.
  function automatic logic [31:0] item_addr(input logic [31:0] bin, input logic [31:0] n,
                                            input logic [31:0] k);
    return bin * n + k;
  endfunction

endpackage

// File: rtl/xfer_phase_cnt.sv
// Phase item counter: counts 0..i_last, wraps to 0 on the terminal count and
// exposes its next value plus a one-hot decode of that next value, so the
// owner can register strobes that line up with the counter itself.
module xfer_phase_cnt
  import sat_bin_pkg::*;
#(
  parameter int unsigned CNT_W = PHASE_CNT_W,
  parameter int unsigned OH_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_last,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_nxt_cnt,
  output logic             o_tc,
  output logic [OH_W-1:0]  o_nxt_onehot
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nxt;

  assign o_tc      = (r_cnt == i_last);
  assign o_cnt     = r_cnt;
  assign o_nxt_cnt = w_nxt;

  // Next count: clear wins, otherwise advance and wrap at the terminal count.
  always_comb begin
    w_nxt = r_cnt;
    if (i_clr) begin
      w_nxt = '0;
    end else if (i_en) begin
      w_nxt = o_tc ? '0 : r_cnt + 1'b1;
    end
  end

  // One-hot decode of the next count value.
  always_comb begin
    o_nxt_onehot = '0;
    for (int j = 0; j < int'(OH_W); j++) begin
      o_nxt_onehot[j] = (w_nxt == CNT_W'(j));
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

endmodule

// File: rtl/bin_xfer_ctrl.sv
// Bin transfer sequencer between the bin memories and the sat engine arrays.
// A load walks clauses, variable states and level states from memory into the
// engine; a store walks them from the engine into memory. Control outputs are
// registered from the next state/count; data paths are combinational.
// Optional macro BIN_XFER_PERF_EN adds a saturating completed-transfer count.
module bin_xfer_ctrl
  import sat_bin_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES_A_BIN     = 8,
  parameter int unsigned NUM_VARS_A_BIN        = 8,
  parameter int unsigned NUM_LVLS_A_BIN        = 8,
  parameter int unsigned WIDTH_BIN_ID          = 10,
  parameter int unsigned WIDTH_VAR_STATES      = 11,
  parameter int unsigned WIDTH_LVL_STATES      = 19,
  parameter int unsigned ADDR_WIDTH_CLAUSES    = 9,
  parameter int unsigned ADDR_WIDTH_VAR_STATES = 9,
  parameter int unsigned ADDR_WIDTH_LVL_STATES = 9
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         load_i,
  input  logic                                         store_i,
  input  logic [WIDTH_BIN_ID-1:0]                      bin_id_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic [NUM_CLAUSES_A_BIN-1:0]                 wr_carray_o,
  output logic [NUM_CLAUSES_A_BIN-1:0]                 rd_carray_o,
  output logic [NUM_VARS_A_BIN*2-1:0]                  clause_o,
  input  logic [NUM_VARS_A_BIN*2-1:0]                  clause_i,
  output logic [NUM_VARS_A_BIN-1:0]                    wr_var_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   var_states_o,
  input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   var_states_i,
  output logic [NUM_LVLS_A_BIN-1:0]                    wr_lvl_states_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_o,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_i,
  output logic [ADDR_WIDTH_CLAUSES-1:0]                cmem_addr_o,
  output logic                                         cmem_we_o,
  output logic [NUM_VARS_A_BIN*2-1:0]                  cmem_wdata_o,
  input  logic [NUM_VARS_A_BIN*2-1:0]                  cmem_rdata_i,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]             vmem_addr_o,
  output logic                                         vmem_we_o,
  output logic [WIDTH_VAR_STATES-1:0]                  vmem_wdata_o,
  input  logic [WIDTH_VAR_STATES-1:0]                  vmem_rdata_i,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]             lmem_addr_o,
  output logic                                         lmem_we_o,
  output logic [WIDTH_LVL_STATES-1:0]                  lmem_wdata_o,
  input  logic [WIDTH_LVL_STATES-1:0]                  lmem_rdata_i
`ifdef BIN_XFER_PERF_EN
  ,
  output logic [15:0]                                  xfer_cnt_o
`endif
);

  localparam int unsigned NC    = NUM_CLAUSES_A_BIN;
  localparam int unsigned NV    = NUM_VARS_A_BIN;
  localparam int unsigned NL    = NUM_LVLS_A_BIN;
  localparam int unsigned CNT_W = phase_cnt_w(NC, NV, NL);
  localparam int unsigned OH_W  = max3(NC, NV, NL) + 1;
  localparam int unsigned WV    = WIDTH_VAR_STATES;
  localparam int unsigned WL    = WIDTH_LVL_STATES;

  xfer_state_e r_state, w_nxt_state;
  logic [WIDTH_BIN_ID-1:0] r_bin, w_bin;

  logic [CNT_W-1:0] w_cnt, w_nxt_cnt, w_last;
  logic             w_tc, w_cnt_en;
  logic [OH_W-1:0]  w_nxt_oh;

  logic [ADDR_WIDTH_CLAUSES-1:0]    w_item_c, w_caddr, r_caddr;
  logic [ADDR_WIDTH_VAR_STATES-1:0] w_item_v, w_vaddr, r_vaddr;
  logic [ADDR_WIDTH_LVL_STATES-1:0] w_item_l, w_laddr, r_laddr;
  logic [NC-1:0] w_wr_carray, r_wr_carray, w_rd_carray, r_rd_carray;
  logic [NV-1:0] w_wr_var, r_wr_var;
  logic [NL-1:0] w_wr_lvl, r_wr_lvl;
  logic w_cwe, w_vwe, w_lwe, r_cwe, r_vwe, r_lwe;
  logic r_busy, r_done;

  // Load phases run k=0..N (one extra cycle for read latency); store phases k=0..N-1.
  always_comb begin
    case (r_state)
      L_CLS:   w_last = CNT_W'(NC);
      L_VAR:   w_last = CNT_W'(NV);
      L_LVL:   w_last = CNT_W'(NL);
      S_CLS:   w_last = CNT_W'(NC - 1);
      S_VAR:   w_last = CNT_W'(NV - 1);
      S_LVL:   w_last = CNT_W'(NL - 1);
      default: w_last = '0;
    endcase
  end

  assign w_cnt_en = (r_state != IDLE) && (r_state != DONE);

  xfer_phase_cnt #(
    .CNT_W (CNT_W),
    .OH_W  (OH_W)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (!w_cnt_en),
    .i_en         (w_cnt_en),
    .i_last       (w_last),
    .o_cnt        (w_cnt),
    .o_nxt_cnt    (w_nxt_cnt),
    .o_tc         (w_tc),
    .o_nxt_onehot (w_nxt_oh)
  );

  // Next state: store beats load on a simultaneous request; busy requests are dropped.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE: begin
        if (store_i)     w_nxt_state = S_CLS;
        else if (load_i) w_nxt_state = L_CLS;
      end
      L_CLS:   if (w_tc) w_nxt_state = L_VAR;
      L_VAR:   if (w_tc) w_nxt_state = L_LVL;
      L_LVL:   if (w_tc) w_nxt_state = DONE;
      S_CLS:   if (w_tc) w_nxt_state = S_VAR;
      S_VAR:   if (w_tc) w_nxt_state = S_LVL;
      S_LVL:   if (w_tc) w_nxt_state = DONE;
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // The bin id is taken straight from the input on the accept cycle.
  assign w_bin    = (r_state == IDLE) ? bin_id_i : r_bin;
  assign w_item_c = ADDR_WIDTH_CLAUSES'(item_addr(32'(w_bin), 32'(NC), 32'(w_nxt_cnt)));
  assign w_item_v = ADDR_WIDTH_VAR_STATES'(item_addr(32'(w_bin), 32'(NV), 32'(w_nxt_cnt)));
  assign w_item_l = ADDR_WIDTH_LVL_STATES'(item_addr(32'(w_bin), 32'(NL), 32'(w_nxt_cnt)));

  // Control outputs for the coming cycle, decoded from next state and next count.
  always_comb begin
    w_wr_carray = '0;
    w_rd_carray = '0;
    w_wr_var    = '0;
    w_wr_lvl    = '0;
    w_caddr     = '0;
    w_vaddr     = '0;
    w_laddr     = '0;
    w_cwe       = 1'b0;
    w_vwe       = 1'b0;
    w_lwe       = 1'b0;
    case (w_nxt_state)
      L_CLS: begin
        w_wr_carray = w_nxt_oh[NC:1];
        if (w_nxt_cnt < CNT_W'(NC)) w_caddr = w_item_c;
      end
      L_VAR: begin
        w_wr_var = w_nxt_oh[NV:1];
        if (w_nxt_cnt < CNT_W'(NV)) w_vaddr = w_item_v;
      end
      L_LVL: begin
        w_wr_lvl = w_nxt_oh[NL:1];
        if (w_nxt_cnt < CNT_W'(NL)) w_laddr = w_item_l;
      end
      S_CLS: begin
        w_rd_carray = w_nxt_oh[NC-1:0];
        w_caddr     = w_item_c;
        w_cwe       = 1'b1;
      end
      S_VAR: begin
        w_vaddr = w_item_v;
        w_vwe   = 1'b1;
      end
      S_LVL: begin
        w_laddr = w_item_l;
        w_lwe   = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state, latched bin id and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_carray <= '0;
      r_rd_carray <= '0;
      r_wr_var    <= '0;
      r_wr_lvl    <= '0;
      r_caddr     <= '0;
      r_vaddr     <= '0;
      r_laddr     <= '0;
      r_cwe       <= 1'b0;
      r_vwe       <= 1'b0;
      r_lwe       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      if (r_state == IDLE) r_bin <= bin_id_i;
      r_busy      <= (w_nxt_state != IDLE);
      r_done      <= (w_nxt_state == DONE);
      r_wr_carray <= w_wr_carray;
      r_rd_carray <= w_rd_carray;
      r_wr_var    <= w_wr_var;
      r_wr_lvl    <= w_wr_lvl;
      r_caddr     <= w_caddr;
      r_vaddr     <= w_vaddr;
      r_laddr     <= w_laddr;
      r_cwe       <= w_cwe;
      r_vwe       <= w_vwe;
      r_lwe       <= w_lwe;
    end
  end

  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign wr_carray_o     = r_wr_carray;
  assign rd_carray_o     = r_rd_carray;
  assign wr_var_states_o = r_wr_var;
  assign wr_lvl_states_o = r_wr_lvl;
  assign cmem_addr_o     = r_caddr;
  assign vmem_addr_o     = r_vaddr;
  assign lmem_addr_o     = r_laddr;
  assign cmem_we_o       = r_cwe;
  assign vmem_we_o       = r_vwe;
  assign lmem_we_o       = r_lwe;

  // Load data: memory read data lands in the strobed slot, every other slot is zero.
  assign clause_o = (|r_wr_carray) ? cmem_rdata_i : '0;

  always_comb begin
    var_states_o = '0;
    for (int j = 0; j < int'(NV); j++) begin
      if (r_wr_var[j]) var_states_o[j*WV +: WV] = vmem_rdata_i;
    end
  end

  always_comb begin
    lvl_states_o = '0;
    for (int j = 0; j < int'(NL); j++) begin
      if (r_wr_lvl[j]) lvl_states_o[j*WL +: WL] = lmem_rdata_i;
    end
  end

  // Store data: the engine item for the current count goes straight to memory.
  assign cmem_wdata_o = r_cwe ? clause_i : '0;

  always_comb begin
    vmem_wdata_o = '0;
    for (int j = 0; j < int'(NV); j++) begin
      if (r_vwe && (w_cnt == CNT_W'(j))) vmem_wdata_o = var_states_i[j*WV +: WV];
    end
  end

  always_comb begin
    lmem_wdata_o = '0;
    for (int j = 0; j < int'(NL); j++) begin
      if (r_lwe && (w_cnt == CNT_W'(j))) lmem_wdata_o = lvl_states_i[j*WL +: WL];
    end
  end

`ifdef BIN_XFER_PERF_EN
  logic [15:0] r_xfer_cnt;

  // Completed-transfer count, saturating at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xfer_cnt <= '0;
    end else if (r_done && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt_o = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_bin_xfer_ctrl.sv
// Directed bench for bin_xfer_ctrl: table-driven load trace plus hand-written
// store, collision, busy-request, mid-transfer reset and optional counter cases.
module tb_bin_xfer_ctrl;

  localparam int NC   = 8;
  localparam int NV   = 8;
  localparam int NL   = 8;
  localparam int BW   = 10;
  localparam int WV   = 11;
  localparam int WL   = 19;
  localparam int AW   = 9;
  localparam int CW   = 2 * NV;
  localparam int MAXC = 36;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              load_i = 1'b0, store_i = 1'b0;
  logic [BW-1:0]     bin_id_i = '0;
  logic              busy_o, done_o;
  logic [NC-1:0]     wr_carray_o, rd_carray_o;
  logic [CW-1:0]     clause_o, clause_i;
  logic [NV-1:0]     wr_var_states_o;
  logic [WV*NV-1:0]  var_states_o, var_states_i;
  logic [NL-1:0]     wr_lvl_states_o;
  logic [WL*NL-1:0]  lvl_states_o, lvl_states_i;
  logic [AW-1:0]     cmem_addr_o, vmem_addr_o, lmem_addr_o;
  logic              cmem_we_o, vmem_we_o, lmem_we_o;
  logic [CW-1:0]     cmem_wdata_o, cmem_rdata_i;
  logic [WV-1:0]     vmem_wdata_o, vmem_rdata_i;
  logic [WL-1:0]     lmem_wdata_o, lmem_rdata_i;
`ifdef BIN_XFER_PERF_EN
  logic [15:0]       xfer_cnt_o;
`endif

  bin_xfer_ctrl dut (
    .clk(clk), .rst(rst), .load_i(load_i), .store_i(store_i), .bin_id_i(bin_id_i),
    .busy_o(busy_o), .done_o(done_o),
    .wr_carray_o(wr_carray_o), .rd_carray_o(rd_carray_o),
    .clause_o(clause_o), .clause_i(clause_i),
    .wr_var_states_o(wr_var_states_o), .var_states_o(var_states_o), .var_states_i(var_states_i),
    .wr_lvl_states_o(wr_lvl_states_o), .lvl_states_o(lvl_states_o), .lvl_states_i(lvl_states_i),
    .cmem_addr_o(cmem_addr_o), .cmem_we_o(cmem_we_o), .cmem_wdata_o(cmem_wdata_o),
    .cmem_rdata_i(cmem_rdata_i),
    .vmem_addr_o(vmem_addr_o), .vmem_we_o(vmem_we_o), .vmem_wdata_o(vmem_wdata_o),
    .vmem_rdata_i(vmem_rdata_i),
    .lmem_addr_o(lmem_addr_o), .lmem_we_o(lmem_we_o), .lmem_wdata_o(lmem_wdata_o),
    .lmem_rdata_i(lmem_rdata_i)
`ifdef BIN_XFER_PERF_EN
    , .xfer_cnt_o(xfer_cnt_o)
`endif
  );

  // Bin memories, one-cycle synchronous read; mem_init fills every word with its index.
  logic [CW-1:0] cmem [512];
  logic [WV-1:0] vmem [512];
  logic [WL-1:0] lmem [512];
  logic          mem_init = 1'b0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 512; a++) begin
        cmem[a] <= CW'(a);
        vmem[a] <= WV'(a);
        lmem[a] <= WL'(a);
      end
    end else begin
      cmem_rdata_i <= cmem[cmem_addr_o];
      vmem_rdata_i <= vmem[vmem_addr_o];
      lmem_rdata_i <= lmem[lmem_addr_o];
      if (cmem_we_o) cmem[cmem_addr_o] <= cmem_wdata_o;
      if (vmem_we_o) vmem[vmem_addr_o] <= vmem_wdata_o;
      if (lmem_we_o) lmem[lmem_addr_o] <= lmem_wdata_o;
    end
  end

  // Engine model: clause array read combinationally, loaded clauses captured on strobe.
  logic [CW-1:0] eng_cls [NC];
  logic [CW-1:0] ld_cls  [NC];

  always_comb begin
    clause_i = '0;
    for (int j = 0; j < NC; j++) if (rd_carray_o[j]) clause_i = eng_cls[j];
  end

  always @(posedge clk) begin
    for (int j = 0; j < NC; j++) if (wr_carray_o[j]) ld_cls[j] <= clause_o;
  end

  // Per-cycle trace of one transfer
  logic [AW-1:0]    tr_ca [MAXC+1], tr_va [MAXC+1], tr_la [MAXC+1];
  logic [NC-1:0]    tr_wrc [MAXC+1], tr_rdc [MAXC+1];
  logic [NV-1:0]    tr_wrv [MAXC+1];
  logic [NL-1:0]    tr_wrl [MAXC+1];
  logic [CW-1:0]    tr_cls [MAXC+1], tr_cwd [MAXC+1];
  logic [WV-1:0]    tr_vwd [MAXC+1];
  logic [WL-1:0]    tr_lwd [MAXC+1];
  logic [WV*NV-1:0] tr_vs [MAXC+1];
  logic [WL*NL-1:0] tr_ls [MAXC+1];
  logic             tr_cwe [MAXC+1], tr_vwe [MAXC+1], tr_lwe [MAXC+1];
  logic             tr_done [MAXC+1], tr_busy [MAXC+1];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a request, trace MAXC cycles; optional load pulse and async reset at given cycles.
  task automatic run_xfer(input logic ld, input logic st, input logic [BW-1:0] bin,
                          input int pulse_cyc, input int rst_cyc,
                          output int ndone, output int dcyc);
    ndone   = 0;
    dcyc    = -1;
    load_i  = ld;
    store_i = st;
    bin_id_i = bin;
    for (int c = 1; c <= MAXC; c++) begin
      step();
      load_i   = (c == pulse_cyc);
      store_i  = 1'b0;
      bin_id_i = '1;
      tr_ca[c] = cmem_addr_o;  tr_va[c] = vmem_addr_o;  tr_la[c] = lmem_addr_o;
      tr_wrc[c] = wr_carray_o; tr_rdc[c] = rd_carray_o;
      tr_wrv[c] = wr_var_states_o; tr_wrl[c] = wr_lvl_states_o;
      tr_cls[c] = clause_o;    tr_vs[c] = var_states_o; tr_ls[c] = lvl_states_o;
      tr_cwe[c] = cmem_we_o;   tr_vwe[c] = vmem_we_o;   tr_lwe[c] = lmem_we_o;
      tr_cwd[c] = cmem_wdata_o; tr_vwd[c] = vmem_wdata_o; tr_lwd[c] = lmem_wdata_o;
      tr_done[c] = done_o;     tr_busy[c] = busy_o;
      if (done_o) begin
        ndone++;
        dcyc = c;
      end
      if (c == rst_cyc) begin
        rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", {busy_o, done_o, cmem_we_o, vmem_we_o, lmem_we_o}, '0);
        chk("rst_mid_strobes", {wr_carray_o, rd_carray_o, wr_var_states_o, wr_lvl_states_o}, '0);
        chk("rst_mid_addr", {cmem_addr_o, vmem_addr_o, lmem_addr_o}, '0);
        chk("rst_mid_data", {clause_o, var_states_o, cmem_wdata_o, vmem_wdata_o, lmem_wdata_o}, '0);
        chk("rst_mid_lvl", lvl_states_o, '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
      end
    end
    load_i = 1'b0;
  endtask

  typedef struct {
    int           cyc;
    logic         chk_a;
    logic [AW-1:0] addr;
    logic [7:0]   wrc;
    logic [CW-1:0] cls;
    logic [7:0]   wrv;
    logic [7:0]   wrl;
    logic         done;
    logic         busy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int nd, dc, cnt;
    logic [WV*NV-1:0] exp_v;
    logic [WL*NL-1:0] exp_l;

    // Load of bin 3 with every memory word equal to its address.
    tbl[0]  = '{1,  1'b1, 9'd24, 8'h00, 16'd0,  8'h00, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{2,  1'b1, 9'd25, 8'h01, 16'd24, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{5,  1'b1, 9'd28, 8'h08, 16'd27, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{8,  1'b1, 9'd31, 8'h40, 16'd30, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{9,  1'b0, 9'd0,  8'h80, 16'd31, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[5]  = '{10, 1'b1, 9'd24, 8'h00, 16'd0,  8'h00, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{11, 1'b1, 9'd25, 8'h00, 16'd0,  8'h01, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{18, 1'b0, 9'd0,  8'h00, 16'd0,  8'h80, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{19, 1'b1, 9'd24, 8'h00, 16'd0,  8'h00, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{20, 1'b1, 9'd25, 8'h00, 16'd0,  8'h00, 8'h01, 1'b0, 1'b1};
    tbl[10] = '{27, 1'b0, 9'd0,  8'h00, 16'd0,  8'h00, 8'h80, 1'b0, 1'b1};
    tbl[11] = '{28, 1'b0, 9'd0,  8'h00, 16'd0,  8'h00, 8'h00, 1'b1, 1'b1};
    tbl[12] = '{29, 1'b0, 9'd0,  8'h00, 16'd0,  8'h00, 8'h00, 1'b0, 1'b0};

    for (int j = 0; j < NC; j++) eng_cls[j] = 16'hA500 + CW'(j);
    for (int j = 0; j < NV; j++) var_states_i[j*WV +: WV] = 11'h400 + WV'(j);
    for (int j = 0; j < NL; j++) lvl_states_i[j*WL +: WL] = 19'h40000 + WL'(j);

    // Reset state
    mem_init = 1'b1;
    step();
    mem_init = 1'b0;
    step();
    chk("rst_busy_done", {busy_o, done_o}, '0);
    chk("rst_strobes", {wr_carray_o, rd_carray_o, wr_var_states_o, wr_lvl_states_o}, '0);
    chk("rst_addr", {cmem_addr_o, vmem_addr_o, lmem_addr_o}, '0);
    chk("rst_we", {cmem_we_o, vmem_we_o, lmem_we_o}, '0);
    chk("rst_data", {clause_o, var_states_o, cmem_wdata_o, vmem_wdata_o, lmem_wdata_o}, '0);
    rst = 1'b1;
    step();

    // Load bin 3, table-driven trace check
    run_xfer(1'b1, 1'b0, 10'd3, -1, -1, nd, dc);
    for (int i = 0; i < 13; i++) begin
      int c;
      logic [AW-1:0] a;
      c = tbl[i].cyc;
      a = (c <= 9) ? tr_ca[c] : (c <= 18) ? tr_va[c] : tr_la[c];
      if (tbl[i].chk_a) chk($sformatf("ld_addr_c%0d", c), a, tbl[i].addr);
      chk($sformatf("ld_wrc_c%0d", c), tr_wrc[c], tbl[i].wrc);
      chk($sformatf("ld_clause_c%0d", c), tr_cls[c], tbl[i].cls);
      chk($sformatf("ld_wrv_c%0d", c), tr_wrv[c], tbl[i].wrv);
      chk($sformatf("ld_wrl_c%0d", c), tr_wrl[c], tbl[i].wrl);
      chk($sformatf("ld_done_c%0d", c), tr_done[c], tbl[i].done);
      chk($sformatf("ld_busy_c%0d", c), tr_busy[c], tbl[i].busy);
    end
    exp_v = '0;
    exp_v[WV-1:0] = 11'd24;
    chk("ld_var_slot0_c11", tr_vs[11], exp_v);
    exp_l = '0;
    exp_l[7*WL +: WL] = 19'd31;
    chk("ld_lvl_slot7_c27", tr_ls[27], exp_l);
    chk("ld_ndone", nd, 1);
    chk("ld_done_cyc", dc, 28);
    for (int j = 0; j < NC; j++) chk($sformatf("ld_eng_cls%0d", j), ld_cls[j], 16'd24 + 16'(j));
    cnt = 0;
    for (int c = 1; c <= MAXC; c++) cnt += int'(tr_cwe[c]) + int'(tr_vwe[c]) + int'(tr_lwe[c]);
    chk("ld_no_mem_we", cnt, 0);

    // Store bin 0
    run_xfer(1'b0, 1'b1, 10'd0, -1, -1, nd, dc);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("st_cwe_c%0d", c), tr_cwe[c], 1'b1);
      chk($sformatf("st_caddr_c%0d", c), tr_ca[c], AW'(c - 1));
      chk($sformatf("st_cwd_c%0d", c), tr_cwd[c], 16'hA500 + 16'(c - 1));
      chk($sformatf("st_rdc_c%0d", c), tr_rdc[c], 8'h01 << (c - 1));
      chk($sformatf("st_vaddr_c%0d", c + 8), tr_va[c + 8], AW'(c - 1));
      chk($sformatf("st_vwd_c%0d", c + 8), tr_vwd[c + 8], 11'h400 + 11'(c - 1));
      chk($sformatf("st_lwd_c%0d", c + 16), tr_lwd[c + 16], 19'h40000 + 19'(c - 1));
    end
    chk("st_cwe_c9", tr_cwe[9], 1'b0);
    chk("st_ndone", nd, 1);
    chk("st_done_cyc", dc, 25);
    cnt = 0;
    for (int c = 1; c <= MAXC; c++) cnt += (tr_wrc[c] != 0) ? 1 : 0;
    chk("st_no_wr_carray", cnt, 0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("st_rb_cmem%0d", j), cmem[j], 16'hA500 + 16'(j));
      chk($sformatf("st_rb_vmem%0d", j), vmem[j], 11'h400 + 11'(j));
      chk($sformatf("st_rb_lmem%0d", j), lmem[j], 19'h40000 + 19'(j));
    end

    // Load and store together: store of bin 5 runs, load never executes
    run_xfer(1'b1, 1'b1, 10'd5, -1, -1, nd, dc);
    chk("both_cwe_c1", tr_cwe[1], 1'b1);
    chk("both_caddr_c1", tr_ca[1], 9'd40);
    chk("both_done_cyc", dc, 25);
    chk("both_ndone", nd, 1);
    cnt = 0;
    for (int c = 1; c <= MAXC; c++) cnt += (tr_wrc[c] != 0 || tr_wrv[c] != 0 || tr_wrl[c] != 0) ? 1 : 0;
    chk("both_no_load_strobes", cnt, 0);

    // Load bin 1 with a stray load request at cycle 10
    run_xfer(1'b1, 1'b0, 10'd1, 10, -1, nd, dc);
    chk("busyreq_ndone", nd, 1);
    chk("busyreq_done_cyc", dc, 28);
    chk("busyreq_vaddr_c10", tr_va[10], 9'd8);
    chk("busyreq_laddr_c20", tr_la[20], 9'd9);

    // Reset at cycle 12 of a load of bin 2, then a clean load of bin 4
    run_xfer(1'b1, 1'b0, 10'd2, -1, 12, nd, dc);
    chk("rstabort_wrv_c11", tr_wrv[11], 8'h01);
    chk("rstabort_ndone", nd, 0);
    run_xfer(1'b1, 1'b0, 10'd4, -1, -1, nd, dc);
    chk("after_rst_ndone", nd, 1);
    chk("after_rst_done_cyc", dc, 28);
    for (int j = 0; j < NC; j++) chk($sformatf("after_rst_cls%0d", j), ld_cls[j], 16'd32 + 16'(j));

`ifdef BIN_XFER_PERF_EN
    // Completed-transfer counter and its saturation
    rst = 1'b0;
    #3;
    rst = 1'b1;
    step();
    chk("perf_after_rst", xfer_cnt_o, 16'd0);
    for (int t = 0; t < 3; t++) run_xfer(1'b0, 1'b1, 10'd0, -1, -1, nd, dc);
    chk("perf_three", xfer_cnt_o, 16'd3);
    force dut.r_xfer_cnt = 16'hFFFF;
    step();
    release dut.r_xfer_cnt;
    run_xfer(1'b1, 1'b0, 10'd0, -1, -1, nd, dc);
    chk("perf_ndone", nd, 1);
    chk("perf_saturate", xfer_cnt_o, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
